// File: rtl/seq_mult_ctrl_dp.sv
// Serial pattern detector that launches a WIDTH-cycle shift-add multiply of A x B per accepted match.
// Optional feature: define SEQ_MULT_ACCUM_EN to accumulate products into data_path_out instead of overwriting.
module seq_mult_ctrl_dp #(
    parameter int                 WIDTH   = 4,
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 d_in,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   data_path_out,
    output logic                 busy,
    output logic                 done
);

    localparam int BIT_CW  = $clog2(PAT_LEN + 1);
    localparam int STEP_CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [BIT_CW-1:0]  BITS_FULL = BIT_CW'(PAT_LEN);
    localparam logic [BIT_CW-1:0]  BITS_QUAL = BIT_CW'(PAT_LEN - 1);
    localparam logic [STEP_CW-1:0] STEP_LAST = STEP_CW'(WIDTH - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MULT = 1'b1;

    // Controller state is kept as a plain named register so checkers can bind to it.
    logic [0:0]           state;
    logic [PAT_LEN-2:0]   sreg;
    logic [BIT_CW-1:0]    bit_cnt;
    logic [STEP_CW-1:0]   step_cnt;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplr;
    logic [2*WIDTH-1:0]   prod;

    logic [PAT_LEN-1:0]   window;
    logic                 qualified;
    logic                 match;
    logic [2*WIDTH-1:0]   prod_next;
    logic                 last_step;
    logic [2*WIDTH-1:0]   result_next;

    // Window includes the bit arriving at this edge; the qualifier counts it too.
    assign window    = {sreg, d_in};
    assign qualified = (bit_cnt >= BITS_QUAL);
    assign match     = qualified && (window == PATTERN);

    assign prod_next = prod + (mplr[0] ? mcand : '0);
    assign last_step = (state == S_MULT) && (step_cnt == STEP_LAST);

`ifdef SEQ_MULT_ACCUM_EN
    assign result_next = data_path_out + prod_next;
`else
    assign result_next = prod_next;
`endif

    assign busy = (state == S_MULT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else begin
            sreg <= window[PAT_LEN-2:0];
            if (bit_cnt != BITS_FULL) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            step_cnt      <= '0;
            mcand         <= '0;
            mplr          <= '0;
            prod          <= '0;
            data_path_out <= '0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (match) begin
                        mcand    <= {{WIDTH{1'b0}}, A};
                        mplr     <= B;
                        prod     <= '0;
                        step_cnt <= '0;
                        state    <= S_MULT;
                    end
                end
                S_MULT: begin
                    prod     <= prod_next;
                    mcand    <= mcand << 1;
                    mplr     <= mplr >> 1;
                    step_cnt <= step_cnt + 1'b1;
                    // Matches seen here, including on the completing edge, are intentionally ignored.
                    if (last_step) begin
                        data_path_out <= result_next;
                        done          <= 1'b1;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_ctrl_dp.sv
// Self-checking bench for seq_mult_ctrl_dp: directed serial patterns checked every cycle against a
// transaction-level model, plus literal expectations. Honors SEQ_MULT_ACCUM_EN like the design.
module tb_seq_mult_ctrl_dp;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         d_in = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [2*W-1:0] data_path_out;
    logic         busy;
    logic         done;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    // Model: bits seen since reset, cycles until the pending product lands, scoreboard of products.
    logic [3:0]     m_hist = '0;
    int             m_nbits = 0;
    int             m_left = 0;
    logic [2*W-1:0] m_out = '0;
    logic           m_done = 1'b0;
    logic [2*W-1:0] exp_q[$];

    always #5 clk = ~clk;

    seq_mult_ctrl_dp #(.WIDTH(W), .PAT_LEN(4), .PATTERN(4'b1101)) dut (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .A(a_in), .B(b_in),
        .data_path_out(data_path_out), .busy(busy), .done(done)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic d, input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [2*W-1:0] p;
        if (!r) begin
            m_hist = '0;
            m_nbits = 0;
            m_left = 0;
            m_out = '0;
            m_done = 1'b0;
            exp_q.delete();
        end else begin
            m_hist = {m_hist[2:0], d};
            if (m_nbits < 4) m_nbits++;
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    p = exp_q.pop_front();
`ifdef SEQ_MULT_ACCUM_EN
                    m_out = m_out + p;
`else
                    m_out = p;
`endif
                    m_done = 1'b1;
                end
            end else if (m_nbits >= 4 && m_hist == 4'b1101) begin
                exp_q.push_back({4'b0, av} * {4'b0, bv});
                m_left = W;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic d, input logic [W-1:0] av, input logic [W-1:0] bv);
        rst_n = r;
        d_in = d;
        a_in = av;
        b_in = bv;
        @(posedge clk);
        #1;
        model_update(r, d, av, bv);
        check("busy", {15'b0, busy}, {15'b0, (m_left > 0)});
        check("done", {15'b0, done}, {15'b0, m_done});
        check("out", {8'b0, data_path_out}, {8'b0, m_out});
        if (done) done_cnt++;
        if (busy) busy_cnt++;
    endtask

    task automatic send(input logic [15:0] bits, input int n, input logic [W-1:0] av, input logic [W-1:0] bv);
        for (int i = n - 1; i >= 0; i--) cycle(1'b1, bits[i], av, bv);
    endtask

    task automatic idle(input int n, input logic [W-1:0] av, input logic [W-1:0] bv);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, av, bv);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom_range(0, 1)), '0, '0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Reset with random data, then reset while shifting 1,1,0 and release on a 1.
        do_reset(2);
        check("rst_out", {8'b0, data_path_out}, 16'h0000);
        check("rst_busy", {15'b0, busy}, 16'h0000);
        check("rst_done", {15'b0, done}, 16'h0000);
        cycle(1'b0, 1'b1, '0, '0);
        cycle(1'b0, 1'b1, '0, '0);
        cycle(1'b0, 1'b0, '0, '0);
        cycle(1'b1, 1'b1, 4'd11, 4'd6);
        check("no_early_match", {15'b0, busy}, 16'h0000);
        idle(3, '0, '0);

        // Single op 11*6.
        do_reset(1);
        done_cnt = 0;
        busy_cnt = 0;
        send(16'b1101, 4, 4'b1011, 4'b0110);
        idle(5, '0, '0);
        check("single_out", {8'b0, data_path_out}, 16'h0042);
        check("single_done_cnt", 16'(done_cnt), 16'd1);
        check("single_busy_cycles", 16'(busy_cnt), 16'd4);

        // Overlapping match dropped while busy, then re-launch right after done.
        do_reset(1);
        done_cnt = 0;
        send(16'b1101101, 7, 4'd3, 4'd5);
        send(16'b101, 3, 4'd7, 4'd2);
        check("overlap_one_done", 16'(done_cnt), 16'd1);
        check("overlap_relaunch_busy", {15'b0, busy}, 16'h0001);
        idle(6, '0, '0);
        check("overlap_two_done", 16'(done_cnt), 16'd2);

        // Operand change during MULT has no effect.
        do_reset(1);
        send(16'b1101, 4, 4'hF, 4'hF);
        idle(6, '0, '0);
        check("hold_out", {8'b0, data_path_out}, 16'h00E1);

        // Reset two edges into MULT aborts the op.
        do_reset(1);
        done_cnt = 0;
        send(16'b1101, 4, 4'd7, 4'd9);
        idle(2, 4'd7, 4'd9);
        do_reset(1);
        check("abort_out", {8'b0, data_path_out}, 16'h0000);
        check("abort_busy", {15'b0, busy}, 16'h0000);
        idle(4, '0, '0);
        check("abort_no_done", 16'(done_cnt), 16'd0);
        send(16'b1101, 4, 4'd2, 4'd3);
        idle(5, '0, '0);
        check("after_abort_out", {8'b0, data_path_out}, 16'h0006);

        // Two ops: overwrite vs accumulate.
        do_reset(1);
        send(16'b1101, 4, 4'd11, 4'd6);
        idle(5, '0, '0);
        check("mode_first", {8'b0, data_path_out}, 16'h0042);
        send(16'b1101, 4, 4'd15, 4'd15);
        idle(5, '0, '0);
`ifdef SEQ_MULT_ACCUM_EN
        check("mode_second", {8'b0, data_path_out}, 16'h0023);
`else
        check("mode_second", {8'b0, data_path_out}, 16'h00E1);
`endif

        // A few extra operand pairs, checked by the model only.
        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            send(16'b1101, 4, ra, rb);
            idle(i % 3, ra ^ 4'hA, rb ^ 4'h5);
        end
        idle(6, '0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
